// File: rtl/sram_2port_bank_ctrl_if.sv
// Request/response bus between the datapath (master) and the SRAM bank sequencer (slave).
interface sram_2port_bank_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr_a;
  logic [ADDR_W-1:0] req_addr_b;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_rdata_a;
  logic [WIDTH-1:0]  rsp_rdata_b;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr_a, req_addr_b, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata_a, rsp_rdata_b, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr_a, req_addr_b, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata_a, rsp_rdata_b, rsp_err
  );
endinterface

// File: rtl/sram_2port_bank_ctrl.sv
// DEPTH x WIDTH two-port SRAM bank (port A r/w, port B read-only) with its
// srclk / word-line access sequencer; one valid/ready request per access.
module sram_2port_bank_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int PRE_CYCLES = 2,
  parameter int WL_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_2port_bank_ctrl_if.slave bus,
  output logic                  srclk_p,
  output logic                  srclk_n,
  output logic                  pen,
  output logic                  pen_n,
  output logic [DEPTH-1:0]      word_a,
  output logic [DEPTH-1:0]      word_b
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLK_DN, S_WL_ON, S_CLK_UP, S_WL_OFF, S_RESP
  } state_t;

  localparam int CNT_MAX = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WL_LAST  = CNT_W'(WL_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [DEPTH-1:0]  ONE      = DEPTH'(1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  rdata_a_q, rdata_b_q;
  logic              err_q;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic accept, capture, a_ok, b_ok, wl_on;

  assign accept  = (state == S_IDLE) && bus.req_valid;
  assign capture = (state == S_WL_ON) && (cnt == WL_LAST);
  assign a_ok    = {1'b0, addr_a_q} < DEPTH_X;
  assign b_ok    = {1'b0, addr_b_q} < DEPTH_X;
  assign wl_on   = (state == S_WL_ON) || (state == S_CLK_UP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_CLK_DN;
          cnt_d   = '0;
        end
      end
      S_CLK_DN: begin
        if (cnt == PRE_LAST) begin
          state_d = S_WL_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_WL_ON: begin
        if (cnt == WL_LAST) begin
          state_d = S_CLK_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_CLK_UP: begin
        if (cnt == PRE_LAST) begin
          state_d = S_WL_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_WL_OFF: state_d = S_RESP;
      S_RESP:   if (bus.rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      we_q     <= bus.req_we;
      addr_a_q <= bus.req_addr_a;
      addr_b_q <= bus.req_addr_b;
      wdata_q  <= bus.req_wdata;
    end
  end

  // Read data is taken from the pre-write contents on the same edge that commits the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      err_q     <= 1'b0;
    end else if (capture) begin
      rdata_a_q <= a_ok ? mem[addr_a_q] : '0;
      rdata_b_q <= b_ok ? mem[addr_b_q] : '0;
      err_q     <= !a_ok || !b_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (capture && we_q && a_ok) mem[addr_a_q] <= wdata_q;
  end

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.rsp_valid   = (state == S_RESP);
  assign bus.rsp_rdata_a = rdata_a_q;
  assign bus.rsp_rdata_b = rdata_b_q;
  assign bus.rsp_err     = err_q;

  assign srclk_p = !((state == S_CLK_DN) || (state == S_WL_ON));
  assign srclk_n = !srclk_p;
  assign pen     = we_q && (state inside {S_CLK_DN, S_WL_ON, S_CLK_UP, S_WL_OFF});
  assign pen_n   = !pen;
  assign word_a  = (wl_on && a_ok) ? (ONE << addr_a_q) : '0;
  assign word_b  = (wl_on && b_ok) ? (ONE << addr_b_q) : '0;

endmodule

// File: tb/tb_sram_2port_bank_ctrl.sv
// Bench for sram_2port_bank_ctrl: timeline/scoreboard model checked every cycle,
// plus directed literal checks (DEPTH=16 main instance, DEPTH=10 range instance).
module tb_sram_2port_bank_ctrl;
  localparam int P = 2;
  localparam int W = 2;
  localparam int D = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sram_2port_bank_ctrl_if #(.WIDTH(8), .ADDR_W(4)) bus ();
  logic        srclk_p, srclk_n, pen, pen_n;
  logic [15:0] word_a, word_b;

  sram_2port_bank_ctrl #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .PRE_CYCLES(P), .WL_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .srclk_p(srclk_p), .srclk_n(srclk_n), .pen(pen), .pen_n(pen_n),
    .word_a(word_a), .word_b(word_b)
  );

  sram_2port_bank_ctrl_if #(.WIDTH(8), .ADDR_W(4)) bus10 ();
  logic       srclk_p10, srclk_n10, pen10, pen_n10;
  logic [9:0] word_a10, word_b10;

  sram_2port_bank_ctrl #(.WIDTH(8), .DEPTH(10), .ADDR_W(4), .PRE_CYCLES(P), .WL_CYCLES(W)) dut10 (
    .clk(clk), .reset(reset), .bus(bus10.slave),
    .srclk_p(srclk_p10), .srclk_n(srclk_n10), .pen(pen10), .pen_n(pen_n10),
    .word_a(word_a10), .word_b(word_b10)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Behavioural model: k = edges since the accept edge; the access timeline follows from k.
  bit         m_busy = 1'b0;
  int         m_k = 0;
  logic       m_we = 1'b0;
  logic [3:0] m_a = '0, m_b = '0;
  logic [7:0] m_wd = '0;
  logic [7:0] m_mem [D];
  bit         m_known [D];
  logic [7:0] e_ra = '0, e_rb = '0;
  logic       e_err = 1'b0;
  bit         e_known = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_we   = 1'b0;
      e_ra   = '0;
      e_rb   = '0;
      e_err  = 1'b0;
    end else if (m_busy) begin
      if (m_k >= 2*P+W+1 && bus.rsp_ready) begin
        m_busy = 1'b0;
      end else begin
        m_k++;
        if (m_k == P+W) begin
          e_ra    = (int'(m_a) < D) ? m_mem[m_a] : 8'h00;
          e_rb    = (int'(m_b) < D) ? m_mem[m_b] : 8'h00;
          e_err   = !(int'(m_a) < D) || !(int'(m_b) < D);
          e_known = m_known[m_a] && m_known[m_b];
          if (m_we && int'(m_a) < D) begin
            m_mem[m_a]   = m_wd;
            m_known[m_a] = 1'b1;
          end
        end
      end
    end else if (bus.req_valid) begin
      m_busy = 1'b1;
      m_k    = 0;
      m_we   = bus.req_we;
      m_a    = bus.req_addr_a;
      m_b    = bus.req_addr_b;
      m_wd   = bus.req_wdata;
    end
  end

  int          lo_run = 0, hi_run = 0;
  logic        prev_srclk = 1'b1, prev_wl = 1'b0;
  logic [31:0] prev_words = '0;

  always @(negedge clk) begin
    logic        on, e_srclk, e_pen, e_rv, wl_any;
    logic [15:0] ewa, ewb;
    on      = m_busy && m_k >= P && m_k < 2*P+W;
    e_srclk = !(m_busy && m_k < P+W);
    e_pen   = m_busy && m_k <= 2*P+W && m_we;
    e_rv    = m_busy && m_k >= 2*P+W+1;
    ewa = '0;
    ewb = '0;
    if (on) begin
      ewa[m_a] = 1'b1;
      ewb[m_b] = 1'b1;
    end
    chk("req_ready", bus.req_ready, !m_busy);
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("srclk_p", srclk_p, e_srclk);
    chk("srclk_n", srclk_n, !e_srclk);
    chk("pen", pen, e_pen);
    chk("pen_n", pen_n, !e_pen);
    chk("word_a", word_a, ewa);
    chk("word_b", word_b, ewb);
    if (e_rv) begin
      chk("rsp_err", bus.rsp_err, e_err);
      if (e_known) begin
        chk("rsp_rdata_a", bus.rsp_rdata_a, e_ra);
        chk("rsp_rdata_b", bus.rsp_rdata_b, e_rb);
      end
    end
    wl_any = (|word_a) || (|word_b);
    if (reset) begin
      if (wl_any && !prev_wl) chk("wl_rise_setup", lo_run >= P, 1'b1);
      if (!wl_any && prev_wl) chk("wl_fall_setup", hi_run >= P, 1'b1);
      if (srclk_p != prev_srclk) chk("wl_still_on_srclk_edge", {word_a, word_b} == prev_words, 1'b1);
      chk("word_a_onehot0", $onehot0(word_a), 1'b1);
      chk("word_b_onehot0", $onehot0(word_b), 1'b1);
    end
    lo_run     = srclk_p ? 0 : lo_run + 1;
    hi_run     = srclk_p ? hi_run + 1 : 0;
    prev_srclk = srclk_p;
    prev_wl    = wl_any;
    prev_words = {word_a, word_b};
  end

  logic       nx_we;
  logic [3:0] nx_a, nx_b;
  logic [7:0] nx_wd;

  task automatic txn(input bit we, input logic [3:0] a, input logic [3:0] b, input logic [7:0] wd,
                     input int hold, input bit keep_next,
                     output logic [7:0] ra, output logic [7:0] rb, output int lat, output int acc_wait,
                     output logic [15:0] wa_seen, output logic [15:0] wb_seen);
    bit rdy, ok;
    bus.req_we     = we;
    bus.req_addr_a = a;
    bus.req_addr_b = b;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    bus.rsp_ready  = 1'b0;
    acc_wait = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      acc_wait++;
      if (rdy) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("accept");
    bus.req_valid = 1'b0;
    lat = 0;
    wa_seen = '0;
    wb_seen = '0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      lat++;
      wa_seen |= word_a;
      wb_seen |= word_b;
      if (bus.rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("rsp_valid");
    ra = bus.rsp_rdata_a;
    rb = bus.rsp_rdata_b;
    for (int i = 0; i < hold; i++) begin
      if (keep_next) begin
        bus.req_we     = nx_we;
        bus.req_addr_a = nx_a;
        bus.req_addr_b = nx_b;
        bus.req_wdata  = nx_wd;
        bus.req_valid  = 1'b1;
      end
      chk("bp_rsp_valid_held", bus.rsp_valid, 1'b1);
      chk("bp_req_ready_low", bus.req_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic t10(input bit we, input logic [3:0] a, input logic [3:0] b, input logic [7:0] wd,
                     output logic [7:0] ra, output logic [7:0] rb, output logic err,
                     output logic [9:0] wl_seen);
    bit rdy, ok;
    bus10.req_we     = we;
    bus10.req_addr_a = a;
    bus10.req_addr_b = b;
    bus10.req_wdata  = wd;
    bus10.req_valid  = 1'b1;
    bus10.rsp_ready  = 1'b0;
    wl_seen = '0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rdy = bus10.req_ready;
      @(posedge clk);
      #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("d10_accept");
    bus10.req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      wl_seen |= word_a10 | word_b10;
      if (bus10.rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("d10_rsp_valid");
    ra  = bus10.rsp_rdata_a;
    rb  = bus10.rsp_rdata_b;
    err = bus10.rsp_err;
    bus10.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus10.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;
    logic [9:0]  wl10;
    logic        err10;
    int          lat, accw;
    bit          ok;

    for (int i = 0; i < D; i++) m_known[i] = 1'b0;
    bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr_a = '0;  bus.req_addr_b = '0;
    bus.req_wdata = '0;    bus.rsp_ready = 1'b0;
    bus10.req_valid = 1'b0; bus10.req_we = 1'b0; bus10.req_addr_a = '0; bus10.req_addr_b = '0;
    bus10.req_wdata = '0;   bus10.rsp_ready = 1'b0;
    nx_we = 1'b0; nx_a = '0; nx_b = '0; nx_wd = '0;

    #1;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rdata_a", bus.rsp_rdata_a, 8'h00);
    chk("rst_rdata_b", bus.rsp_rdata_b, 8'h00);
    chk("rst_err", bus.rsp_err, 1'b0);
    chk("rst_srclk_p", srclk_p, 1'b1);
    chk("rst_srclk_n", srclk_n, 1'b0);
    chk("rst_pen", pen, 1'b0);
    chk("rst_pen_n", pen_n, 1'b1);
    chk("rst_word_a", word_a, 16'h0000);
    chk("rst_word_b", word_b, 16'h0000);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // Preload known contents.
    txn(1'b1, 4'd3,  4'd3,  8'h3C, 0, 1'b0, ra, rb, lat, accw, wa, wb);
    txn(1'b1, 4'd1,  4'd1,  8'h11, 0, 1'b0, ra, rb, lat, accw, wa, wb);
    txn(1'b1, 4'd14, 4'd14, 8'hEE, 0, 1'b0, ra, rb, lat, accw, wa, wb);
    txn(1'b1, 4'd5,  4'd5,  8'h55, 0, 1'b0, ra, rb, lat, accw, wa, wb);

    // Write then read: old data returned on write, 7-edge latency.
    txn(1'b1, 4'd3, 4'd3, 8'hA5, 0, 1'b0, ra, rb, lat, accw, wa, wb);
    chk("wr_old_rdata_b", rb, 8'h3C);
    chk("wr_old_rdata_a", ra, 8'h3C);
    chk("wr_latency", lat, 7);
    txn(1'b0, 4'd3, 4'd3, 8'h00, 0, 1'b0, ra, rb, lat, accw, wa, wb);
    chk("rd_after_wr_a", ra, 8'hA5);
    chk("rd_latency", lat, 7);
    chk("same_addr_word_a", wa, 16'h0008);
    chk("same_addr_word_b", wb, 16'h0008);

    // Dual read.
    txn(1'b0, 4'd1, 4'd14, 8'h00, 0, 1'b0, ra, rb, lat, accw, wa, wb);
    chk("dual_rdata_a", ra, 8'h11);
    chk("dual_rdata_b", rb, 8'hEE);
    chk("dual_word_a", wa, 16'h0002);
    chk("dual_word_b", wb, 16'h4000);

    // Backpressure with a second request already pending.
    nx_we = 1'b1; nx_a = 4'd7; nx_b = 4'd3; nx_wd = 8'h77;
    txn(1'b0, 4'd3, 4'd14, 8'h00, 5, 1'b1, ra, rb, lat, accw, wa, wb);
    chk("bp_rdata_a", ra, 8'hA5);
    chk("bp_rdata_b", rb, 8'hEE);
    chk("bp_req_ready_idle", bus.req_ready, 1'b1);
    txn(nx_we, nx_a, nx_b, nx_wd, 0, 1'b0, ra, rb, lat, accw, wa, wb);
    chk("bp_next_accept_edges", accw, 1);
    chk("bp_next_rdata_b", rb, 8'hA5);
    txn(1'b0, 4'd7, 4'd5, 8'h00, 0, 1'b0, ra, rb, lat, accw, wa, wb);
    chk("bp_next_written", ra, 8'h77);
    chk("bp_rdata_b_5", rb, 8'h55);

    // Asynchronous reset mid WL_ON aborts a write.
    bus.req_we = 1'b1; bus.req_addr_a = 4'd5; bus.req_addr_b = 4'd1; bus.req_wdata = 8'h99;
    bus.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      if (word_a != 16'h0000) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("reset_test_wl_on");
    #2 reset = 1'b0;
    #1;
    chk("arst_word_a", word_a, 16'h0000);
    chk("arst_word_b", word_b, 16'h0000);
    chk("arst_srclk_p", srclk_p, 1'b1);
    chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("arst_pen", pen, 1'b0);
    chk("arst_req_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    txn(1'b0, 4'd5, 4'd1, 8'h00, 0, 1'b0, ra, rb, lat, accw, wa, wb);
    chk("arst_write_aborted", ra, 8'h55);
    chk("arst_rdata_b", rb, 8'h11);

    // DEPTH=10 instance: out-of-range accesses.
    t10(1'b1, 4'd4, 4'd4, 8'h44, ra, rb, err10, wl10);
    chk("d10_inrange_err", err10, 1'b0);
    chk("d10_inrange_wl", wl10, 10'h010);
    t10(1'b1, 4'd12, 4'd11, 8'hFF, ra, rb, err10, wl10);
    chk("d10_oor_err", err10, 1'b1);
    chk("d10_oor_no_wl", wl10, 10'h000);
    chk("d10_oor_rdata_a", ra, 8'h00);
    chk("d10_oor_rdata_b", rb, 8'h00);
    t10(1'b0, 4'd4, 4'd12, 8'h00, ra, rb, err10, wl10);
    chk("d10_mem_unchanged", ra, 8'h44);
    chk("d10_mixed_rdata_b", rb, 8'h00);
    chk("d10_mixed_err", err10, 1'b1);
    chk("d10_mixed_wl", wl10, 10'h010);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
